// File: rtl/collision_flag_reader.sv
// collision_flag_reader
// Read side of the collision flag bus. Each analysis pass ends with a 1->0
// edge on process_finished. Two cycles after that edge the 30-bit flag bus
// (a 2-bit code per mobile sprite) is ORed into sticky per-sprite registers.
// The CPU side reads one sprite's code over a 4-phase req/valid handshake and
// can optionally clear that sprite's code on read.
//
// Ports
//   clk               single clock, all state on posedge
//   reset             asynchronous, active-low
//   collision_flags   flag bus, code for sprite i at [2i+1:2i]
//   process_finished  analysis pass status, a 1->0 edge triggers a capture
//   rd_request        read request level (4-phase)
//   rd_sprite         sprite index, sampled with the request
//   rd_clear          clear-on-read, sampled with the request
//   rd_valid          response valid, held until rd_request drops
//   rd_code           00 none, 01 mobile, 10 fixed, 11 both
//   rd_error          index >= mobile_sprites
//   new_frame         1-cycle pulse when a snapshot is merged
//   any_collision     registered OR of all sticky bits
module collision_flag_reader #(
  parameter int bits_to_sprite = 5,
  parameter int bits_to_flags  = 30,
  parameter int mobile_sprites = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [bits_to_flags-1:0]  collision_flags,
  input  logic                      process_finished,
  input  logic                      rd_request,
  input  logic [bits_to_sprite-1:0] rd_sprite,
  input  logic                      rd_clear,
  output logic                      rd_valid,
  output logic [1:0]                rd_code,
  output logic                      rd_error,
  output logic                      new_frame,
  output logic                      any_collision
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_pf_q;
  logic                      r_cap_pend;
  logic [bits_to_flags-1:0]  r_sticky;
  logic [bits_to_sprite-1:0] r_idx;
  logic                      r_clr;
  logic                      r_valid;
  logic [1:0]                r_code;
  logic                      r_error;
  logic                      r_new_frame;
  logic                      r_any;

  logic                      w_fall;
  logic                      w_idx_ok;
  logic                      w_latch;
  logic                      w_valid_nxt;
  logic [1:0]                w_code_nxt;
  logic                      w_error_nxt;
  logic [bits_to_flags-1:0]  w_clear_mask;
  logic [bits_to_flags-1:0]  w_sticky_nxt;

  // Two-bit code of sprite idx within a flag vector.
  function automatic logic [1:0] sel_code(input logic [bits_to_flags-1:0] vec,
                                          input logic [bits_to_sprite-1:0] idx);
    logic [1:0] c;
    c = 2'b00;
    for (int i = 0; i < mobile_sprites; i++) begin
      if (idx == bits_to_sprite'(i)) begin
        c = vec[2*i +: 2];
      end
    end
    return c;
  endfunction

  // Mask covering the two bits of sprite idx.
  function automatic logic [bits_to_flags-1:0] slice_mask(input logic [bits_to_sprite-1:0] idx);
    logic [bits_to_flags-1:0] m;
    m = '0;
    for (int i = 0; i < mobile_sprites; i++) begin
      if (idx == bits_to_sprite'(i)) begin
        m[2*i +: 2] = 2'b11;
      end
    end
    return m;
  endfunction

  assign w_fall   = r_pf_q & ~process_finished;
  assign w_idx_ok = (r_idx < bits_to_sprite'(mobile_sprites));

  // The clear is applied before the new snapshot is ORed in, so a collision
  // arriving in the same cycle as a clear-on-read survives.
  assign w_sticky_nxt = (r_sticky & ~w_clear_mask) |
                        (r_cap_pend ? collision_flags : {bits_to_flags{1'b0}});

  // Read FSM next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_valid;
    w_code_nxt   = r_code;
    w_error_nxt  = r_error;
    w_latch      = 1'b0;
    w_clear_mask = '0;
    case (r_state)
      ST_IDLE: begin
        if (rd_request) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_LOOKUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        w_valid_nxt = 1'b1;
        w_state_nxt = ST_RESPOND;
        if (w_idx_ok) begin
          // rd_code carries the pre-clear value.
          w_code_nxt  = sel_code(r_sticky, r_idx);
          w_error_nxt = 1'b0;
          if (r_clr) begin
            w_clear_mask = slice_mask(r_idx);
          end else begin
            w_clear_mask = '0;
          end
        end else begin
          w_code_nxt  = 2'b00;
          w_error_nxt = 1'b1;
        end
      end
      ST_RESPOND: begin
        if (!rd_request) begin
          w_valid_nxt = 1'b0;
          w_code_nxt  = 2'b00;
          w_error_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESPOND;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_code_nxt  = 2'b00;
        w_error_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, request latch and registered read outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_clr   <= 1'b0;
      r_valid <= 1'b0;
      r_code  <= 2'b00;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_code  <= w_code_nxt;
      r_error <= w_error_nxt;
      if (w_latch) begin
        r_idx <= rd_sprite;
        r_clr <= rd_clear;
      end else begin
        r_idx <= r_idx;
        r_clr <= r_clr;
      end
    end
  end

  // Edge detect, delayed capture, sticky accumulation and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pf_q      <= 1'b0;
      r_cap_pend  <= 1'b0;
      r_sticky    <= '0;
      r_new_frame <= 1'b0;
      r_any       <= 1'b0;
    end else begin
      r_pf_q      <= process_finished;
      r_cap_pend  <= w_fall;
      r_sticky    <= w_sticky_nxt;
      r_new_frame <= r_cap_pend;
      r_any       <= |r_sticky;
    end
  end

  assign rd_valid      = r_valid;
  assign rd_code       = r_code;
  assign rd_error      = r_error;
  assign new_frame     = r_new_frame;
  assign any_collision = r_any;

endmodule

// File: tb/tb_collision_flag_reader.sv
// Directed testbench for collision_flag_reader. Inputs are driven 1 time unit
// after each rising edge, and outputs are sampled at the same point.
module tb_collision_flag_reader;

  logic        clk;
  logic        reset;
  logic [29:0] collision_flags;
  logic        process_finished;
  logic        rd_request;
  logic [4:0]  rd_sprite;
  logic        rd_clear;
  logic        rd_valid;
  logic [1:0]  rd_code;
  logic        rd_error;
  logic        new_frame;
  logic        any_collision;

  int n_checks;
  int n_fail;

  collision_flag_reader dut (
    .clk              (clk),
    .reset            (reset),
    .collision_flags  (collision_flags),
    .process_finished (process_finished),
    .rd_request       (rd_request),
    .rd_sprite        (rd_sprite),
    .rd_clear         (rd_clear),
    .rd_valid         (rd_valid),
    .rd_code          (rd_code),
    .rd_error         (rd_error),
    .new_frame        (new_frame),
    .any_collision    (any_collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a snapshot and let it settle into the sticky registers.
  task automatic capture(input logic [29:0] f);
    collision_flags  = f;
    process_finished = 1'b1;
    tick();
    process_finished = 1'b0;
    tick(3);
  endtask

  task automatic start_read(input logic [4:0] s, input logic c);
    rd_sprite  = s;
    rd_clear   = c;
    rd_request = 1'b1;
    tick(2);
  endtask

  task automatic end_read();
    rd_request = 1'b0;
    rd_clear   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({rd_valid, rd_code, rd_error, new_frame, any_collision} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {rd_valid, rd_code, rd_error, new_frame, any_collision});
    end
  endtask

  task automatic test_capture();
    collision_flags  = 30'h0000_0004;
    process_finished = 1'b1;
    tick();
    process_finished = 1'b0;
    tick();
    n_checks++;
    if (new_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_early: new_frame=%b expected 0", new_frame);
    end
    tick();
    n_checks++;
    if (new_frame !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_pulse: new_frame=%b expected 1", new_frame);
    end
    n_checks++;
    if (any_collision !== 1'b0) begin
      n_fail++;
      $display("FAIL any_lag: any_collision=%b expected 0", any_collision);
    end
    tick();
    n_checks++;
    if (new_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_one_cycle: new_frame=%b expected 0", new_frame);
    end
    n_checks++;
    if (any_collision !== 1'b1) begin
      n_fail++;
      $display("FAIL any_set: any_collision=%b expected 1", any_collision);
    end
  endtask

  task automatic test_read_basic();
    rd_sprite  = 5'd1;
    rd_clear   = 1'b0;
    rd_request = 1'b1;
    tick();
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_latency: rd_valid=%b expected 0", rd_valid);
    end
    tick();
    n_checks++;
    if ({rd_valid, rd_code, rd_error} !== 4'b1010) begin
      n_fail++;
      $display("FAIL read_sprite1: valid/code/err=%b expected 1010", {rd_valid, rd_code, rd_error});
    end
    // A held request keeps the response stable.
    tick(2);
    n_checks++;
    if ({rd_valid, rd_code} !== 3'b101) begin
      n_fail++;
      $display("FAIL read_hold: valid/code=%b expected 101", {rd_valid, rd_code});
    end
    end_read();
    n_checks++;
    if ({rd_valid, rd_code} !== 3'b000) begin
      n_fail++;
      $display("FAIL read_release: valid/code=%b expected 000", {rd_valid, rd_code});
    end
  endtask

  task automatic test_sticky_or();
    capture(30'h0000_0040);
    capture(30'h0000_0080);
    start_read(5'd3, 1'b0);
    n_checks++;
    if (rd_code !== 2'b11) begin
      n_fail++;
      $display("FAIL sticky_or: rd_code=%b expected 11", rd_code);
    end
    end_read();
  endtask

  task automatic test_clear();
    start_read(5'd1, 1'b1);
    n_checks++;
    if (rd_code !== 2'b01) begin
      n_fail++;
      $display("FAIL clear_preval: rd_code=%b expected 01", rd_code);
    end
    end_read();
    start_read(5'd1, 1'b0);
    n_checks++;
    if ({rd_valid, rd_code} !== 3'b100) begin
      n_fail++;
      $display("FAIL clear_reread: valid/code=%b expected 100", {rd_valid, rd_code});
    end
    end_read();
    start_read(5'd3, 1'b1);
    n_checks++;
    if (rd_code !== 2'b11) begin
      n_fail++;
      $display("FAIL clear_s3_preval: rd_code=%b expected 11", rd_code);
    end
    end_read();
    tick();
    n_checks++;
    if (any_collision !== 1'b0) begin
      n_fail++;
      $display("FAIL any_cleared: any_collision=%b expected 0", any_collision);
    end
  endtask

  task automatic test_error();
    capture(30'h3000_0000);
    start_read(5'd20, 1'b1);
    n_checks++;
    if ({rd_valid, rd_code, rd_error} !== 4'b1001) begin
      n_fail++;
      $display("FAIL error_20: valid/code/err=%b expected 1001", {rd_valid, rd_code, rd_error});
    end
    end_read();
    start_read(5'd15, 1'b1);
    n_checks++;
    if ({rd_valid, rd_code, rd_error} !== 4'b1001) begin
      n_fail++;
      $display("FAIL error_15: valid/code/err=%b expected 1001", {rd_valid, rd_code, rd_error});
    end
    end_read();
    n_checks++;
    if ({rd_error, any_collision} !== 2'b01) begin
      n_fail++;
      $display("FAIL error_release: err/any=%b expected 01", {rd_error, any_collision});
    end
    start_read(5'd14, 1'b0);
    n_checks++;
    if ({rd_valid, rd_code, rd_error} !== 4'b1110) begin
      n_fail++;
      $display("FAIL read_14: valid/code/err=%b expected 1110", {rd_valid, rd_code, rd_error});
    end
    end_read();
  endtask

  task automatic test_clear_capture();
    capture(30'h0000_0001);
    collision_flags  = 30'h0000_0002;
    process_finished = 1'b1;
    tick();
    process_finished = 1'b0;
    rd_sprite  = 5'd0;
    rd_clear   = 1'b1;
    rd_request = 1'b1;
    tick(2);
    n_checks++;
    if ({rd_valid, rd_code, new_frame} !== 4'b1011) begin
      n_fail++;
      $display("FAIL clr_cap_resp: valid/code/nf=%b expected 1011", {rd_valid, rd_code, new_frame});
    end
    end_read();
    start_read(5'd0, 1'b0);
    n_checks++;
    if (rd_code !== 2'b10) begin
      n_fail++;
      $display("FAIL clr_cap_keep: rd_code=%b expected 10", rd_code);
    end
    end_read();
  endtask

  task automatic test_back_to_back();
    start_read(5'd14, 1'b0);
    n_checks++;
    if ({rd_valid, rd_code} !== 3'b111) begin
      n_fail++;
      $display("FAIL pre_reset_read: valid/code=%b expected 111", {rd_valid, rd_code});
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({rd_valid, rd_code, rd_error, new_frame, any_collision} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_respond: outputs=%b expected 000000",
               {rd_valid, rd_code, rd_error, new_frame, any_collision});
    end
    tick();
    reset = 1'b1;
    // Request still high at release must start a fresh read.
    tick();
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fresh_latency: rd_valid=%b expected 0", rd_valid);
    end
    tick();
    n_checks++;
    if ({rd_valid, rd_code, rd_error} !== 4'b1000) begin
      n_fail++;
      $display("FAIL fresh_read: valid/code/err=%b expected 1000", {rd_valid, rd_code, rd_error});
    end
    // Held request must not retrigger; index changes are ignored.
    rd_sprite = 5'd20;
    tick(3);
    n_checks++;
    if ({rd_valid, rd_error} !== 2'b10) begin
      n_fail++;
      $display("FAIL no_retrigger: valid/err=%b expected 10", {rd_valid, rd_error});
    end
    end_read();
    start_read(5'd20, 1'b0);
    n_checks++;
    if ({rd_valid, rd_error} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_read: valid/err=%b expected 11", {rd_valid, rd_error});
    end
    end_read();
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b0;
    collision_flags  = 30'h0;
    process_finished = 1'b0;
    rd_request       = 1'b0;
    rd_sprite        = 5'd0;
    rd_clear         = 1'b0;
    tick(2);
    test_reset();
    reset = 1'b1;
    tick();
    test_capture();
    test_read_basic();
    test_sticky_or();
    test_clear();
    test_error();
    test_clear_capture();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
